pair_pattern_tx: RTL

//  Serial transmitter feeding the pair-detector serial input (two equal bits -> detect).

---
 rtl/pair_pattern_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pair_pattern_tx.sv
// pair_pattern_tx: serial transmitter for the pair-detector input.
// It takes a parallel word on a valid/ready handshake and sends it MSB-first, one bit per cycle.
// It also runs a bit-exact model of the pair detector on every emitted bit.
// The model gives the number of detects the receiver must raise for each word.
module pair_pattern_tx #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic                         hold,
    output logic                         outbit,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   exp_count
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Detector model encoding. 2'b11 is unused and is treated as the start state.
    localparam logic [1:0] M0 = 2'd0;   // start
    localparam logic [1:0] M1 = 2'd1;   // last unpaired bit was a one
    localparam logic [1:0] M2 = 2'd2;   // last unpaired bit was a zero

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        model_q, model_d;
    logic              outbit_q, outbit_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic [CW-1:0]     exp_q, exp_d;
    logic [2:0]        step;

    // One detector step. Result is {detect, next_state}.
    function automatic logic [2:0] model_step(input logic [1:0] m, input logic b);
        logic [2:0] r;
        case (m)
            M1:      r = b ? {1'b1, M0} : {1'b0, M2};
            M2:      r = b ? {1'b0, M1} : {1'b1, M0};
            default: r = b ? {1'b0, M1} : {1'b0, M2};
        endcase
        return r;
    endfunction

    assign step       = model_step(model_q, sr_q[WIDTH-1]);
    assign load_ready = (state_q == IDLE);
    assign busy       = !load_ready;
    assign outbit     = outbit_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign exp_count  = exp_q;

    // Next-state and output logic: accept, shift or stall, and report the word count.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        model_d     = model_q;
        outbit_d    = outbit_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        exp_d       = exp_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    sr_d      = data_in;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    outbit_d    = sr_q[WIDTH-1];
                    out_valid_d = 1'b1;
                    sr_d        = sr_q << 1;
                    bit_cnt_d   = bit_cnt_q + CW'(1);
                    model_d     = step[1:0];
                    if (step[2]) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (bit_cnt_q == CW'(WIDTH-1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                exp_d   = cnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers. Reset aborts any word in flight at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            model_q     <= M0;
            outbit_q    <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            model_q     <= model_d;
            outbit_q    <= outbit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            exp_q       <= exp_d;
        end
    end

    // Shift register holds only data. It is always reloaded on accept, so it has no reset.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

endmodule
